alu_mdu_seq: RTL and testbench
==============================

// Module: alu_mdu_seq
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle datapath ALU. Keeps
//  the 3-bit ALU op set (registered, 1-cycle) and adds an iterative unsigned
//  multiply/divide unit (MDU). Sits between operand fetch and writeback in the
//  multi-cycle CPU; one operation in flight, result held until consumed.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=2)
//  MD_EN  1   1: MDU ops implemented; 0: MDU ops complete in 1 cycle, Result=0
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      op/operands valid
//  in_ready   out  1      block can accept an op (state IDLE)
//  op         in   4      op[3]=0 ALU op, op[3]=1 MDU op (encodings below)
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  out_valid  out  1      Result/flags valid (state DONE)
//  out_ready  in   1      consumer takes result
//  Result     out  WIDTH  registered result
//  Overflow   out  1      signed overflow (ADD/SUB/SLT/SLTU only, else 0)
//  CarryOut   out  1      ADD: carry out; SUB/SLT/SLTU: borrow; else 0
//  Zero       out  1      Result==0
// BEHAVIOUR
//  Ops: 0000 AND, 0001 OR, 0010 ADD, 0011 SLTU, 0100 XOR, 0101 NOR, 0110 SUB,
//   0111 SLT, 1000 MULU low WIDTH bits, 1001 MULU high WIDTH bits, 1010 DIVU
//   quotient, 1011 REMU remainder, 11xx reserved -> Result 0, flags 0.
//  FSM IDLE/CALC/DONE. in_ready=(state==IDLE); out_valid=(state==DONE).
//  Accept = in_valid & in_ready & ~rst; A, B, op captured that edge, later
//   input changes ignored.
//  IDLE: accept ALU op, reserved op, or any op with MD_EN=0 -> DONE (out_valid
//   exactly 1 cycle after accept). Accept MDU op (MD_EN=1) -> CALC, counter=WIDTH.
//  CALC: one step/cycle, counter decrements; after WIDTH steps -> DONE; out_valid
//   exactly WIDTH+1 cycles after accept. in_valid ignored.
//  MULU: shift-add over WIDTH steps, full 2*WIDTH-bit unsigned product; op
//   selects low/high half. DIVU/REMU: restoring division, 1 quotient bit/step.
//  Divide by zero (B==0): quotient all-ones, remainder = A; same latency.
//  Adder: SUB/SLT/SLTU compute A+~B+1; Overflow = sign rule on A, ~B, sum;
//   CarryOut = carry^sub. SLT = sum[MSB]^Overflow, SLTU = borrow, zero-extended.
//  DONE: Result/flags held stable while out_ready=0. out_ready=1 -> IDLE next
//   edge; in_ready rises the cycle after handoff (no same-cycle accept).
//  Reset (any state, incl. mid-CALC): asynchronously state=IDLE, counter=0,
//   out_valid=0, Result=0, Overflow=0, CarryOut=0, Zero=1. No partial result is
//   ever emitted; in-flight op is discarded. in_ready=1 after release.
// TESTING (WIDTH=32 unless noted)
//  ADD 0x7FFFFFFF+0x1 -> Result 0x80000000, Overflow 1, CarryOut 0, Zero 0,
//   out_valid 1 cycle after accept.
//  SUB 0x0-0x1 -> 0xFFFFFFFF, CarryOut 1; SLT 0xFFFFFFFF,0x1 -> 1; SLTU same
//   operands -> 0, Zero 1.
//  MULU 0xFFFFFFFF*0xFFFFFFFF: op 1001 -> 0xFFFFFFFE, op 1000 -> 0x00000001;
//   out_valid exactly 33 cycles after accept, in_ready 0 throughout.
//  DIVU 100/7 -> 14, REMU -> 2; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
//  Hold out_ready=0 5 cycles in DONE -> outputs stable, in_ready 0; raise
//   out_ready -> in_ready 1 next cycle; WIDTH=8 MULU 0xFF*0xFF -> hi 0xFE in 9.
//  Assert rst at step 10 of DIVU -> out_valid 0 immediately, no result; after
//   release ADD 3+4 -> 7 normally.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// Handshaked ALU with an iterative unsigned multiply/divide unit.
// One op in flight: IDLE accepts, CALC iterates MDU ops, DONE holds the result until it is consumed.
module alu_mdu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MD_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             Zero
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            cout_q, cout_d;
  logic            zero_q, zero_d;

  // Single-cycle ALU on the live inputs, consumed only on the accept edge
  logic             alu_sub_c, add_carry_c, add_ovf_c, add_brw_c;
  logic [WIDTH-1:0] b_eff_c, add_sum_c, alu_res_c;
  logic             alu_ovf_c, alu_cout_c;

  always_comb begin
    alu_sub_c = (op == 4'b0110) || (op == 4'b0111) || (op == 4'b0011);
    b_eff_c   = alu_sub_c ? ~B : B;
    {add_carry_c, add_sum_c} = {1'b0, A} + {1'b0, b_eff_c} + W1'(alu_sub_c);
    add_ovf_c = (A[WIDTH-1] == b_eff_c[WIDTH-1]) && (add_sum_c[WIDTH-1] != A[WIDTH-1]);
    add_brw_c = add_carry_c ^ alu_sub_c;
    alu_res_c  = '0;
    alu_ovf_c  = 1'b0;
    alu_cout_c = 1'b0;
    case (op)
      4'b0000: alu_res_c = A & B;
      4'b0001: alu_res_c = A | B;
      4'b0100: alu_res_c = A ^ B;
      4'b0101: alu_res_c = ~(A | B);
      4'b0010, 4'b0110: begin
        alu_res_c  = add_sum_c;
        alu_ovf_c  = add_ovf_c;
        alu_cout_c = add_brw_c;
      end
      4'b0011: begin
        alu_res_c  = WIDTH'(add_brw_c);
        alu_ovf_c  = add_ovf_c;
        alu_cout_c = add_brw_c;
      end
      4'b0111: begin
        alu_res_c  = WIDTH'(add_sum_c[WIDTH-1] ^ add_ovf_c);
        alu_ovf_c  = add_ovf_c;
        alu_cout_c = add_brw_c;
      end
      default: alu_res_c = '0;
    endcase
  end

  // One MDU step: acc holds {hi, lo} for multiply and {rem, quo} for divide
  logic [WIDTH:0]   mul_sum_c, div_shift_c, div_diff_c;
  logic             div_ge_c;
  logic [W2-1:0]    mul_next_c, div_next_c, step_next_c;
  logic [WIDTH-1:0] mdu_res_c;

  always_comb begin
    mul_sum_c   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, b_q};
    mul_next_c  = acc_q[0] ? {mul_sum_c, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};
    div_shift_c = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_c    = div_shift_c >= {1'b0, b_q};
    div_diff_c  = div_shift_c - {1'b0, b_q};
    div_next_c  = div_ge_c ? {div_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {div_shift_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    step_next_c = op_q[1] ? div_next_c : mul_next_c;
    mdu_res_c   = op_q[0] ? step_next_c[W2-1:WIDTH] : step_next_c[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if ((MD_EN != 0) && (op[3:2] == 2'b10)) begin
            state_d = CALC;
            cnt_d   = CW'(WIDTH);
            op_d    = op[1:0];
            b_d     = B;
            acc_d   = {{WIDTH{1'b0}}, A};
          end else begin
            // Reserved ops and disabled MDU ops fall through the ALU case default as 0
            state_d = DONE;
            res_d   = alu_res_c;
            ovf_d   = alu_ovf_c;
            cout_d  = alu_cout_c;
            zero_d  = (alu_res_c == '0);
          end
        end
      end
      CALC: begin
        acc_d = step_next_c;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          res_d   = mdu_res_c;
          ovf_d   = 1'b0;
          cout_d  = 1'b0;
          zero_d  = (mdu_res_c == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = res_q;
  assign Overflow  = ovf_q;
  assign CarryOut  = cout_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq: 32-bit instance for ALU/MDU/handshake/reset, 8-bit instance for MULU latency.
module tb_alu_mdu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b, result;
  logic        ovf, cout, zero;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, result8;
  logic        ovf8, cout8, zero8;

  alu_mdu_seq #(.WIDTH(32), .MD_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .Result(result),
    .Overflow(ovf), .CarryOut(cout), .Zero(zero)
  );

  alu_mdu_seq #(.WIDTH(8), .MD_EN(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .A(a8), .B(b8), .out_valid(out_valid8), .out_ready(out_ready8), .Result(result8),
    .Overflow(ovf8), .CarryOut(cout8), .Zero(zero8)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] r_res;
  logic        r_ovf, r_cout, r_zero;
  int          lat;
  logic        irs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure cycles from accept to out_valid, sample outputs, then consume
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int l, output logic ir_seen);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0; op = 4'b0000; a = 32'hDEADBEEF; b = 32'h0000_0003;
    l = 1;
    ir_seen = 1'b0;
    while (!out_valid && l < 200) begin
      if (in_ready) ir_seen = 1'b1;
      @(negedge clk);
      l++;
    end
    r_res = result; r_ovf = ovf; r_cout = cout; r_zero = zero;
    check("done_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_flags", 64'({ovf, cout}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    do_op(4'b0010, 32'h7FFF_FFFF, 32'h1, lat, irs);
    check("add_res", 64'(r_res), 64'h8000_0000);
    check("add_ovf", 64'(r_ovf), 64'd1);
    check("add_cout", 64'(r_cout), 64'd0);
    check("add_zero", 64'(r_zero), 64'd0);
    check("add_lat", 64'(lat), 64'd1);

    do_op(4'b0010, 32'hFFFF_FFFF, 32'h1, lat, irs);
    check("add_carry_res", 64'(r_res), 64'd0);
    check("add_carry_flags", 64'({r_ovf, r_cout, r_zero}), 64'b011);

    do_op(4'b0110, 32'h0, 32'h1, lat, irs);
    check("sub_res", 64'(r_res), 64'hFFFF_FFFF);
    check("sub_cout", 64'(r_cout), 64'd1);
    check("sub_ovf", 64'(r_ovf), 64'd0);

    do_op(4'b0111, 32'hFFFF_FFFF, 32'h1, lat, irs);
    check("slt_res", 64'(r_res), 64'd1);

    do_op(4'b0011, 32'hFFFF_FFFF, 32'h1, lat, irs);
    check("sltu_res", 64'(r_res), 64'd0);
    check("sltu_zero", 64'(r_zero), 64'd1);

    do_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, lat, irs);
    check("and_res", 64'(r_res), 64'h00F0_1200);
    do_op(4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, lat, irs);
    check("or_res", 64'(r_res), 64'hFFF0_FF34);
    do_op(4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00, lat, irs);
    check("xor_res", 64'(r_res), 64'hFF00_ED34);
    do_op(4'b0101, 32'hF0F0_1234, 32'h0FF0_FF00, lat, irs);
    check("nor_res", 64'(r_res), 64'h000F_00CB);
    check("nor_flags", 64'({r_ovf, r_cout}), 64'd0);

    do_op(4'b1100, 32'h1234_5678, 32'h9, lat, irs);
    check("rsvd_res", 64'(r_res), 64'd0);
    check("rsvd_lat", 64'(lat), 64'd1);

    do_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, irs);
    check("mulhi_res", 64'(r_res), 64'hFFFF_FFFE);
    check("mulhi_lat", 64'(lat), 64'd33);
    check("mulhi_in_ready_busy", 64'(irs), 64'd0);
    do_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, irs);
    check("mullo_res", 64'(r_res), 64'h0000_0001);
    check("mullo_flags", 64'({r_ovf, r_cout, r_zero}), 64'd0);
    do_op(4'b1000, 32'h0001_2345, 32'h0000_1000, lat, irs);
    check("mullo_shift", 64'(r_res), 64'h1234_5000);

    do_op(4'b1010, 32'd100, 32'd7, lat, irs);
    check("divu_res", 64'(r_res), 64'd14);
    check("divu_lat", 64'(lat), 64'd33);
    do_op(4'b1011, 32'd100, 32'd7, lat, irs);
    check("remu_res", 64'(r_res), 64'd2);
    do_op(4'b1010, 32'd5, 32'd0, lat, irs);
    check("divu0_res", 64'(r_res), 64'hFFFF_FFFF);
    check("divu0_lat", 64'(lat), 64'd33);
    do_op(4'b1011, 32'd5, 32'd0, lat, irs);
    check("remu0_res", 64'(r_res), 64'd5);
    do_op(4'b1010, 32'hFFFF_FFFF, 32'h8000_0000, lat, irs);
    check("divu_big", 64'(r_res), 64'd1);

    // Result held while the consumer stalls
    @(negedge clk);
    in_valid = 1'b1; op = 4'b0110; a = 32'd10; b = 32'd3;
    @(negedge clk);
    in_valid = 1'b0; a = 32'h0; b = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_res", 64'(result), 64'd7);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_release_in_ready", 64'(in_ready), 64'd1);
    check("hold_release_valid", 64'(out_valid), 64'd0);

    // 8-bit multiply
    @(negedge clk);
    in_valid8 = 1'b1; op8 = 4'b1001; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    lat = 1;
    while (!out_valid8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("mul8_hi", 64'(result8), 64'hFE);
    check("mul8_lat", 64'(lat), 64'd9);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check("mul8_in_ready", 64'(in_ready8), 64'd1);

    // Reset in the middle of a divide discards it
    @(negedge clk);
    in_valid = 1'b1; op = 4'b1010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_zero", 64'(zero), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    irs = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) irs = 1'b1;
      @(negedge clk);
    end
    check("mid_rst_no_result", 64'(irs), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    do_op(4'b0010, 32'd3, 32'd4, lat, irs);
    check("post_rst_add", 64'(r_res), 64'd7);
    check("post_rst_lat", 64'(lat), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
